// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and buffers words for decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched_o / perf_stall_o handshake counters.
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, req_pc_q;
  logic             outstanding_q, discard_q;
  fetch_entry_t     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  fetch_entry_t     head;

  logic redirect_en, grant, rsp_en, push, pop;
  logic [1:0] unused_pc_bits;

  assign unused_pc_bits = redirect_pc_i[1:0];

  // Handshake qualifiers; a redirect kills any push or pop in its cycle.
  assign redirect_en = redirect_i && (state_q != BOOT);
  assign grant       = imem_req_o && imem_gnt_i;
  assign rsp_en      = imem_rvalid_i && outstanding_q;
  assign push        = rsp_en && !discard_q && !redirect_en;
  assign pop         = valid_o && ready_i && !redirect_en;
  assign head        = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_i && outstanding_q && !imem_rvalid_i) state_d = FLUSH;
      FLUSH:   if (imem_rvalid_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req_o    = 1'b0;
    imem_addr_o   = pc_q;
    valid_o       = (count_q != '0);
    instruction_o = NOP_INSN;
    pc_o          = '0;
    if (state_q == RUN && !redirect_i && !outstanding_q && count_q < CNT_W'(FIFO_DEPTH))
      imem_req_o = 1'b1;
    if (valid_o) begin
      instruction_o = head.insn;
      pc_o          = head.pc;
    end
  end

  // PC, in-flight tracking and stale-response discard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      if (redirect_en)  pc_q <= {redirect_pc_i[31:2], 2'b00};
      else if (grant)   pc_q <= pc_q + XLEN'(4);
      if (grant) begin
        outstanding_q <= 1'b1;
        req_pc_q      <= pc_q;
      end else if (rsp_en) begin
        outstanding_q <= 1'b0;
      end
      if (redirect_en)  discard_q <= outstanding_q && !imem_rvalid_i;
      else if (rsp_en)  discard_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_en) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{insn: imem_rdata_i, pc: req_pc_q};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (valid_o && ready_i)  perf_fetched_o <= perf_fetched_o + 32'd1;
      if (valid_o && !ready_i) perf_stall_o   <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: reactive imem model plus a queue-based reference of the decode stream.
// Define FETCH_PERF_CNT_EN to also exercise the performance counters.
module tb_pipeline_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic        redirect_i = 1'b0, valid_o, ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, instruction_o, pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_stall_o;
`endif

  pipeline_fetch_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i), .instruction_o(instruction_o), .pc_o(pc_o)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: decode-visible queue, next fetch address, one in-flight request and its stale flag.
  ent_t        q[$];
  logic        pending = 1'b0, stale = 1'b0, boot = 1'b1;
  logic [31:0] exp_pc = RST_PC, pend_pc = '0;
  int          exp_fetched = 0, exp_stall = 0;

  // Memory side: in-order single response after a random latency.
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          lat_min = 1, lat_max = 1;
  bit          inject_err = 1'b0;

  logic [31:0] dut_grant[$];
  logic [31:0] dut_xfer[$];
  logic        obs_valid, obs_req;
  logic [31:0] obs_pc, obs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_F00F) + 32'h0001_0000;
  endfunction

  task automatic cycle(input logic gnt, input logic rdy, input logic redir, input logic [31:0] rpc);
    logic rv, gnt_eff, exp_req, exp_valid, redir_eff;
    logic [31:0] rd;
    ent_t head, e;
    @(negedge clk_i);
    rv = 1'b0;
    rd = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = mem_word(mem_addr);
        mem_busy = 1'b0;
      end
    end else if (inject_err && $urandom_range(0, 15) == 0) begin
      rv = 1'b1;
    end
    gnt_eff = gnt && !mem_busy;
    imem_gnt_i = gnt_eff; imem_rvalid_i = rv; imem_rdata_i = rd;
    ready_i = rdy; redirect_i = redir; redirect_pc_i = rpc;
    #1;
    redir_eff = redir && !boot;
    exp_valid = (q.size() != 0);
    exp_req   = !boot && !redir && !pending && (q.size() < DEPTH);
    obs_valid = valid_o; obs_req = imem_req_o; obs_pc = pc_o; obs_addr = imem_addr_o;
    n_checks++;
    if (valid_o !== exp_valid) begin
      n_errors++;
      $display("FAIL valid_o @%0t: got %b want %b", $time, valid_o, exp_valid);
    end
    if (exp_valid) begin
      head = q[0];
      n_checks++;
      if (instruction_o !== head.insn || pc_o !== head.pc) begin
        n_errors++;
        $display("FAIL head @%0t: got insn=%h pc=%h want insn=%h pc=%h", $time, instruction_o, pc_o, head.insn, head.pc);
      end
    end else begin
      n_checks++;
      if (instruction_o !== NOP || pc_o !== 32'h0) begin
        n_errors++;
        $display("FAIL idle_out @%0t: got insn=%h pc=%h want insn=%h pc=0", $time, instruction_o, pc_o, NOP);
      end
    end
    n_checks++;
    if (imem_req_o !== exp_req) begin
      n_errors++;
      $display("FAIL imem_req_o @%0t: got %b want %b", $time, imem_req_o, exp_req);
    end
    if (exp_req) begin
      n_checks++;
      if (imem_addr_o !== exp_pc) begin
        n_errors++;
        $display("FAIL imem_addr_o @%0t: got %h want %h", $time, imem_addr_o, exp_pc);
      end
    end
    if (imem_req_o && gnt_eff) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_min, lat_max);
      mem_addr = imem_addr_o;
      dut_grant.push_back(imem_addr_o);
    end
    if (valid_o && rdy && !redir_eff) dut_xfer.push_back(pc_o);
    if (exp_valid && rdy)  exp_fetched++;
    if (exp_valid && !rdy) exp_stall++;
    if (redir_eff) begin
      q.delete();
      exp_pc = {rpc[31:2], 2'b00};
      if (pending) begin
        if (rv) begin pending = 1'b0; stale = 1'b0; end
        else stale = 1'b1;
      end
    end else begin
      if (exp_valid && rdy) q.delete(0);
      if (rv && pending) begin
        if (!stale) begin
          e.insn = rd; e.pc = pend_pc;
          q.push_back(e);
        end
        pending = 1'b0; stale = 1'b0;
      end
      if (exp_req && gnt_eff) begin
        pending = 1'b1; pend_pc = exp_pc; exp_pc = exp_pc + 32'd4;
      end
    end
    boot = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; ready_i = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b0 || instruction_o !== NOP || pc_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_out: got valid=%b req=%b insn=%h pc=%h want 0 0 %h 0", valid_o, imem_req_o, instruction_o, pc_o, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_fetched_o !== 32'h0 || perf_stall_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_perf: got %0d %0d want 0 0", perf_fetched_o, perf_stall_o);
    end
`endif
    q.delete(); pending = 1'b0; stale = 1'b0; boot = 1'b1; exp_pc = RST_PC;
    exp_fetched = 0; exp_stall = 0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    dut_grant.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    n_checks++;
    if (obs_req !== 1'b0) begin n_errors++; $display("FAIL boot_req: got %b want 0", obs_req); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin
      n_errors++;
      $display("FAIL first_req: got req=%b addr=%h want 1 %h", obs_req, obs_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    lat_min = 1; lat_max = 1;
    dut_grant.delete(); dut_xfer.delete();
    repeat (16) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut_grant.size() <= i) begin n_errors++; $display("FAIL seq_addr[%0d]: got none want %h", i, 4 * i); end
      else if (dut_grant[i] !== 32'(4 * i)) begin
        n_errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, dut_grant[i], 4 * i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dut_xfer.size() <= i) begin n_errors++; $display("FAIL seq_pc[%0d]: got none want %h", i, 4 * i); end
      else if (dut_xfer[i] !== 32'(4 * i)) begin
        n_errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, dut_xfer[i], 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat_min = 1; lat_max = 1;
    dut_xfer.delete();
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_req !== 1'b0 || obs_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL stall_hold: got valid=%b req=%b pc=%h want 1 0 0", obs_valid, obs_req, obs_pc);
    end
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dut_xfer.size() <= i || dut_xfer[i] !== 32'(4 * i)) begin
        n_errors++; $display("FAIL stall_resume[%0d]: got %0d entries want pc %h", i, dut_xfer.size(), 4 * i);
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    int guard = 0;
    do_reset();
    lat_min = 3; lat_max = 3;
    while (!(mem_busy && mem_cnt >= 2) && guard < 20) begin cycle(1'b1, 1'b1, 1'b0, 32'h0); guard++; end
    n_checks++;
    if (guard >= 20) begin n_errors++; $display("FAIL redir_wait: got no in-flight request want one"); end
    dut_grant.delete(); dut_xfer.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL redir_valid: got %b want 0", obs_valid); end
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (dut_grant.size() == 0 || dut_grant[0] !== 32'h0000_0100) begin
      n_errors++; $display("FAIL redir_addr: got %0d grants want first 00000100", dut_grant.size());
    end
    n_checks++;
    if (dut_xfer.size() == 0 || dut_xfer[0] !== 32'h0000_0100) begin
      n_errors++; $display("FAIL redir_pc: got %0d xfers want first 00000100", dut_xfer.size());
    end
  endtask

  task automatic test_redirect_rvalid();
    int guard = 0;
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    while (!(mem_busy && mem_cnt == 1 && q.size() != 0) && guard < 30) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0); guard++;
    end
    n_checks++;
    if (guard >= 30) begin n_errors++; $display("FAIL coinc_wait: got no due response want one"); end
    dut_xfer.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0200) begin
      n_errors++; $display("FAIL coinc_req: got req=%b addr=%h want 1 00000200", obs_req, obs_addr);
    end
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (dut_xfer.size() == 0 || dut_xfer[0] !== 32'h0000_0200) begin
      n_errors++; $display("FAIL coinc_pc: got %0d xfers want first 00000200", dut_xfer.size());
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    lat_min = 1; lat_max = 1;
    dut_grant.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    while (dut_grant.size() < 3 && guard < 40) begin cycle(1'b1, 1'b1, 1'b0, 32'h0); guard++; end
    n_checks++;
    if (dut_grant.size() < 3 || dut_grant[0] !== 32'hFFFF_FFF8 || dut_grant[1] !== 32'hFFFF_FFFC
        || dut_grant[2] !== 32'h0000_0000) begin
      n_errors++; $display("FAIL wrap_addr: got %0d grants want FFFFFFF8 FFFFFFFC 00000000", dut_grant.size());
    end
  endtask

  task automatic test_reset_midop();
    int guard = 0;
    lat_min = 3; lat_max = 3;
    dut_xfer.delete();
    while (!(dut_xfer.size() >= 2 && mem_busy) && guard < 60) begin cycle(1'b1, 1'b1, 1'b0, 32'h0); guard++; end
    n_checks++;
    if (guard >= 60) begin n_errors++; $display("FAIL midop_wait: got no in-flight request want one"); end
    do_reset();
    dut_xfer.delete();
    repeat (14) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (dut_xfer.size() == 0 || dut_xfer[0] !== RST_PC) begin
      n_errors++; $display("FAIL midop_pc: got %0d xfers want first %h", dut_xfer.size(), RST_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3; inject_err = 1'b1;
    dut_xfer.delete();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
    end
    inject_err = 1'b0;
    n_checks++;
    if (dut_xfer.size() < 100) begin n_errors++; $display("FAIL rand_progress: got %0d xfers want >=100", dut_xfer.size()); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    int guard = 0;
    do_reset();
    lat_min = 1; lat_max = 1;
    while (exp_fetched < 10 && guard < 200) begin
      cycle(1'b1, !(exp_fetched >= 4 && exp_stall < 3), 1'b0, 32'h0);
      guard++;
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (perf_fetched_o !== 32'd10 || perf_stall_o !== 32'd3) begin
      n_errors++; $display("FAIL perf: got fetched=%0d stall=%0d want 10 3", perf_fetched_o, perf_stall_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_outstanding();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midop();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
